// File: rtl/ctrl_rv32i_pkg.sv
// ctrl_rv32i_pkg: RV32I opcodes, control-field encodings and the decoded control bundle
package ctrl_rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [2:0] BT_ALWAYS = 3'b111;

    typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100} imm_e;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_LOGIC = 2'b01, ALU_SHIFT = 2'b10, ALU_SLT = 2'b11} alu_e;
    typedef enum logic [1:0] {GA_AND = 2'b00, GA_OR = 2'b01, GA_XOR = 2'b10} ga_e;
    typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b11} sh_e;
    typedef enum logic [1:0] {RD_ALU = 2'b00, RD_LOAD = 2'b01, RD_PC4 = 2'b10, RD_IMM = 2'b11} rd_e;

    typedef struct packed {
        logic       alu1_src;
        logic       alu2_src;
        imm_e       imm_type;
        alu_e       alu_type;
        logic       ad_type;
        ga_e        ga_type;
        sh_e        sh_type;
        logic       sl_type;
        rd_e        rd_type;
        logic       rd_write;
        logic [2:0] load_type;
        logic       store;
        logic [1:0] store_type;
        logic       branch;
        logic [2:0] branch_type;
        logic       pc_type;
    } ctrl_t;

endpackage

// File: rtl/ctrl_unit_rv32i_if.sv
// ctrl_unit_rv32i_if: instruction fields in, decoded control fields out
//   master: instruction source (drives opcode/funct3/funct7, reads cu_*)
//   slave : control unit (reads instruction fields, drives cu_*)
//   cu_illegal exists only when CTRL_UNIT_ILLEGAL_EN is defined
interface ctrl_unit_rv32i_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       cu_ALU1src;
    logic       cu_ALU2src;
    logic [2:0] cu_immtype;
    logic [1:0] cu_ALUtype;
    logic       cu_adtype;
    logic [1:0] cu_gatype;
    logic [1:0] cu_shiftype;
    logic       cu_sltype;
    logic [1:0] cu_rdtype;
    logic       cu_rdwrite;
    logic [2:0] cu_loadtype;
    logic       cu_store;
    logic [1:0] cu_storetype;
    logic       cu_branch;
    logic [2:0] cu_branchtype;
    logic       cu_PCtype;
`ifdef CTRL_UNIT_ILLEGAL_EN
    logic       cu_illegal;
`endif

    modport master (
`ifdef CTRL_UNIT_ILLEGAL_EN
        input  cu_illegal,
`endif
        output opcode, funct3, funct7,
        input  cu_ALU1src, cu_ALU2src, cu_immtype, cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype,
               cu_sltype, cu_rdtype, cu_rdwrite, cu_loadtype, cu_store, cu_storetype, cu_branch,
               cu_branchtype, cu_PCtype
    );

    modport slave (
`ifdef CTRL_UNIT_ILLEGAL_EN
        output cu_illegal,
`endif
        input  opcode, funct3, funct7,
        output cu_ALU1src, cu_ALU2src, cu_immtype, cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype,
               cu_sltype, cu_rdtype, cu_rdwrite, cu_loadtype, cu_store, cu_storetype, cu_branch,
               cu_branchtype, cu_PCtype
    );
endinterface

// File: rtl/ctrl_decode_rv32i.sv
// ctrl_decode_rv32i: combinational RV32I decode of opcode/funct3/funct7 into a ctrl_t bundle
//   opcode, funct3 in; funct7[5] only (f7_5) unless CTRL_UNIT_ILLEGAL_EN, which takes the full
//   funct7 and adds the illegal output. Unknown opcodes and reserved funct3 decode to all zero.
module ctrl_decode_rv32i
    import ctrl_rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
`ifdef CTRL_UNIT_ILLEGAL_EN
    input  logic [6:0] funct7,
    output logic       illegal,
`else
    input  logic       f7_5,
`endif
    output ctrl_t      c
);
`ifdef CTRL_UNIT_ILLEGAL_EN
    logic f7_5;
    logic f7_bad;
    assign f7_5 = funct7[5];
    // 0x20 is only meaningful for SUB/SRA (R) and SRAI (I); I-type non-shifts carry immediate bits there
    assign f7_bad = opcode == OP_R ? !(funct7 == 7'h00 || (funct7 == 7'h20 && funct3[1:0] == 2'b00 && !funct3[2]) || (funct7 == 7'h20 && funct3 == 3'b101))
                  : funct3 == 3'b001 ? funct7 != 7'h00
                  : funct3 == 3'b101 ? !(funct7 == 7'h00 || funct7 == 7'h20)
                  : 1'b0;
`endif
    always_comb begin
        c = '0;
`ifdef CTRL_UNIT_ILLEGAL_EN
        illegal = 1'b0;
`endif
        case (opcode)
            OP_R, OP_I: begin
                c.alu2_src = opcode == OP_I;
                c.rd_write = 1'b1;
                c.alu_type = funct3 == 3'b000 ? ALU_ADD : funct3[1:0] == 2'b01 ? ALU_SHIFT : funct3[2:1] == 2'b01 ? ALU_SLT : ALU_LOGIC;
                c.ad_type  = opcode == OP_R && funct3 == 3'b000 && f7_5;
                c.ga_type  = funct3 == 3'b100 ? GA_XOR : funct3 == 3'b110 ? GA_OR : GA_AND;
                c.sh_type  = funct3 == 3'b101 ? (f7_5 ? SH_SRA : SH_SRL) : SH_SLL;
                c.sl_type  = funct3 == 3'b011;
`ifdef CTRL_UNIT_ILLEGAL_EN
                illegal = f7_bad;
`endif
            end
            OP_LOAD: begin
                if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
                    c.alu2_src  = 1'b1;
                    c.rd_type   = RD_LOAD;
                    c.rd_write  = 1'b1;
                    c.load_type = funct3;
                end
`ifdef CTRL_UNIT_ILLEGAL_EN
                else illegal = 1'b1;
`endif
            end
            OP_STORE: begin
                if (funct3 < 3'd3) begin
                    c.alu2_src   = 1'b1;
                    c.imm_type   = IMM_S;
                    c.store      = 1'b1;
                    c.store_type = funct3[1:0];
                end
`ifdef CTRL_UNIT_ILLEGAL_EN
                else illegal = 1'b1;
`endif
            end
            OP_BRANCH: begin
                if (funct3[2:1] != 2'b01) begin
                    c.alu1_src    = 1'b1;
                    c.alu2_src    = 1'b1;
                    c.imm_type    = IMM_B;
                    c.branch      = 1'b1;
                    c.pc_type     = 1'b1;
                    c.branch_type = {funct3[2] ^ funct3[0], funct3[1], funct3[0]};
                end
`ifdef CTRL_UNIT_ILLEGAL_EN
                else illegal = 1'b1;
`endif
            end
            OP_LUI: begin
                c.alu2_src = 1'b1;
                c.imm_type = IMM_U;
                c.rd_type  = RD_IMM;
                c.rd_write = 1'b1;
            end
            OP_AUIPC: begin
                c.alu1_src = 1'b1;
                c.alu2_src = 1'b1;
                c.imm_type = IMM_U;
                c.rd_write = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                c.alu1_src    = opcode == OP_JAL;
                c.alu2_src    = 1'b1;
                c.imm_type    = opcode == OP_JAL ? IMM_J : IMM_I;
                c.rd_type     = RD_PC4;
                c.rd_write    = 1'b1;
                c.branch      = 1'b1;
                c.pc_type     = 1'b1;
                c.branch_type = BT_ALWAYS;
            end
            default: begin
`ifdef CTRL_UNIT_ILLEGAL_EN
                illegal = 1'b1;
`endif
            end
        endcase
    end
endmodule

// File: rtl/ctrl_unit_rv32i.sv
// ctrl_unit_rv32i: RV32I main control unit with registered outputs (1-cycle decode latency)
//   clk, rst : rising-edge clock, async active-high reset (all outputs 0 = NOP)
//   bus      : slave side of ctrl_unit_rv32i_if (instruction fields in, cu_* out)
//   CTRL_UNIT_ILLEGAL_EN adds the registered cu_illegal flag
module ctrl_unit_rv32i
    import ctrl_rv32i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ctrl_unit_rv32i_if.slave     bus
);
    ctrl_t d, q;
`ifdef CTRL_UNIT_ILLEGAL_EN
    logic ill_d;
    ctrl_decode_rv32i u_dec (.opcode(bus.opcode), .funct3(bus.funct3), .funct7(bus.funct7), .illegal(ill_d), .c(d));
    always_ff @(posedge clk or posedge rst)
        if (rst) bus.cu_illegal <= 1'b0;
        else bus.cu_illegal <= ill_d;
`else
    ctrl_decode_rv32i u_dec (.opcode(bus.opcode), .funct3(bus.funct3), .f7_5(bus.funct7[5]), .c(d));
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= d;
    assign bus.cu_ALU1src    = q.alu1_src;
    assign bus.cu_ALU2src    = q.alu2_src;
    assign bus.cu_immtype    = q.imm_type;
    assign bus.cu_ALUtype    = q.alu_type;
    assign bus.cu_adtype     = q.ad_type;
    assign bus.cu_gatype     = q.ga_type;
    assign bus.cu_shiftype   = q.sh_type;
    assign bus.cu_sltype     = q.sl_type;
    assign bus.cu_rdtype     = q.rd_type;
    assign bus.cu_rdwrite    = q.rd_write;
    assign bus.cu_loadtype   = q.load_type;
    assign bus.cu_store      = q.store;
    assign bus.cu_storetype  = q.store_type;
    assign bus.cu_branch     = q.branch;
    assign bus.cu_branchtype = q.branch_type;
    assign bus.cu_PCtype     = q.pc_type;
endmodule

// File: tb/tb_ctrl_unit_rv32i.sv
// tb_ctrl_unit_rv32i: directed + random checks of ctrl_unit_rv32i against a field-level reference model
module tb_ctrl_unit_rv32i;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    ctrl_unit_rv32i_if bus ();
    ctrl_unit_rv32i dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [26:0] obs;
    assign obs = {bus.cu_ALU1src, bus.cu_ALU2src, bus.cu_immtype, bus.cu_ALUtype, bus.cu_adtype,
                  bus.cu_gatype, bus.cu_shiftype, bus.cu_sltype, bus.cu_rdtype, bus.cu_rdwrite,
                  bus.cu_loadtype, bus.cu_store, bus.cu_storetype, bus.cu_branch, bus.cu_branchtype,
                  bus.cu_PCtype};

    function automatic logic [26:0] ref_ctrl(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic a1 = 0, a2 = 0, ad = 0, sl = 0, rw = 0, st = 0, br = 0, pc = 0;
        logic [2:0] imm = 0, ld = 0, bt = 0;
        logic [1:0] alut = 0, ga = 0, sh = 0, rd = 0, stt = 0;
        case (op)
            7'h33, 7'h13: begin
                rw = 1;
                a2 = (op == 7'h13);
                if (f3 == 0) alut = 0;
                else if (f3 == 1 || f3 == 5) alut = 2;
                else if (f3 == 2 || f3 == 3) alut = 3;
                else alut = 1;
                ad = (op == 7'h33 && f3 == 0 && f7[5]);
                if (f3 == 4) ga = 2;
                if (f3 == 6) ga = 1;
                if (f3 == 5) sh = f7[5] ? 2'd3 : 2'd1;
                sl = (f3 == 3);
            end
            7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin a2 = 1; rd = 1; rw = 1; ld = f3; end
            7'h23: if (f3 <= 2) begin a2 = 1; imm = 1; st = 1; stt = f3[1:0]; end
            7'h63: if (f3 != 2 && f3 != 3) begin
                a1 = 1; a2 = 1; imm = 2; br = 1; pc = 1;
                case (f3)
                    0: bt = 3'b000;
                    1: bt = 3'b101;
                    4: bt = 3'b100;
                    5: bt = 3'b001;
                    6: bt = 3'b110;
                    default: bt = 3'b011;
                endcase
            end
            7'h37: begin a2 = 1; imm = 3; rd = 3; rw = 1; end
            7'h17: begin a1 = 1; a2 = 1; imm = 3; rw = 1; end
            7'h6f: begin a1 = 1; a2 = 1; imm = 4; rd = 2; rw = 1; br = 1; pc = 1; bt = 7; end
            7'h67: begin a2 = 1; rd = 2; rw = 1; br = 1; pc = 1; bt = 7; end
            default: ;
        endcase
        return {a1, a2, imm, alut, ad, ga, sh, sl, rd, rw, ld, st, stt, br, bt, pc};
    endfunction

    function automatic logic ref_ill(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        case (op)
            7'h33: return !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            7'h13: return (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            7'h03: return !(f3 inside {0, 1, 2, 4, 5});
            7'h23: return f3 > 2;
            7'h63: return f3 == 2 || f3 == 3;
            7'h37, 7'h17, 7'h6f, 7'h67: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [26:0] exp, input logic exp_ill);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
`ifdef CTRL_UNIT_ILLEGAL_EN
        n_cmp++;
        assert (bus.cu_illegal === exp_ill) else begin
            n_err++;
            $error("FAIL %s_illegal observed=%b expected=%b", tag, bus.cu_illegal, exp_ill);
        end
`else
        if (exp_ill === 1'bx) $display("note: unknown illegal expectation in %s", tag);
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.opcode = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        @(posedge clk);
        #1;
        check(tag, ref_ctrl(op, f3, f7), ref_ill(op, f3, f7));
    endtask

    logic [6:0] ops [9];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};
        bus.opcode = 7'h33;
        bus.funct3 = 3'd0;
        bus.funct7 = 7'h00;
        #3;
        check("reset_state", 27'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 27'd0, 1'b0);
        #1 rst = 1'b0;
        step("r_add", 7'h33, 3'd0, 7'h00);
        chk("r_add_rdwrite", bus.cu_rdwrite, 1);
        step("r_sub", 7'h33, 3'd0, 7'h20);
        chk("r_sub_adtype", bus.cu_adtype, 1);
        step("r_sra", 7'h33, 3'd5, 7'h20);
        chk("r_sra_shiftype", bus.cu_shiftype, 3);
        step("r_sltu", 7'h33, 3'd3, 7'h00);
        chk("r_sltu_sltype", bus.cu_sltype, 1);
        step("r_xor", 7'h33, 3'd4, 7'h00);
        chk("r_xor_gatype", bus.cu_gatype, 2);
        // async reset mid-run with a live R opcode on the inputs
        #1 rst = 1'b1;
        #1 check("async_rst", 27'd0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_release_no_edge", 27'd0, 1'b0);
        step("after_release", 7'h33, 3'd4, 7'h00);
        step("lw", 7'h03, 3'd2, 7'h00);
        chk("lw_loadtype", bus.cu_loadtype, 2);
        step("sb", 7'h23, 3'd0, 7'h00);
        chk("sb_rdwrite", bus.cu_rdwrite, 0);
        step("beq", 7'h63, 3'd0, 7'h00);
        step("bne", 7'h63, 3'd1, 7'h00);
        chk("bne_branchtype", bus.cu_branchtype, 3'b101);
        step("bgeu", 7'h63, 3'd7, 7'h00);
        step("lui", 7'h37, 3'd5, 7'h7f);
        step("auipc", 7'h17, 3'd0, 7'h00);
        step("jal", 7'h6f, 3'd3, 7'h00);
        chk("jal_branchtype", bus.cu_branchtype, 3'b111);
        step("jalr", 7'h67, 3'd0, 7'h00);
        chk("jalr_alu1src", bus.cu_ALU1src, 0);
        step("srai", 7'h13, 3'd5, 7'h20);
        step("addi_f7", 7'h13, 3'd0, 7'h20);
        step("unknown_op", 7'h7f, 3'd0, 7'h00);
        step("load_f3_7", 7'h03, 3'd7, 7'h00);
        step("store_f3_3", 7'h23, 3'd3, 7'h00);
        step("branch_f3_2", 7'h63, 3'd2, 7'h00);
        step("r_bad_f7", 7'h33, 3'd1, 7'h20);
        for (int i = 0; i < 400; i++) begin
            int k;
            logic [6:0] op, f7;
            logic [2:0] f3;
            k = int'($urandom_range(0, 10));
            op = k < 9 ? ops[k] : 7'($urandom);
            f3 = 3'($urandom);
            k = int'($urandom_range(0, 3));
            f7 = k == 0 ? 7'h00 : k == 1 ? 7'h20 : 7'($urandom);
            step("random", op, f3, f7);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
